// File: rtl/pulse_sequencer_pkg.sv
// Shared definitions for the pulse sequencer and the PWM pulse counter it
// drives.
//   CW_DEF  : default width of the counter Din field and of segment periods.
//   state_t : sequencer FSM encoding (IDLE=0, LOAD=1, RUN=2).
package pulse_sequencer_pkg;

  localparam int CW_DEF = 34;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } state_t;

endpackage

// File: rtl/pulse_seq_table.sv
// Segment table: DEPTH entries of {width, period}. Each entry is 2*CW bits.
// Writes are synchronous. The read is combinational. Contents are not reset.
//   clock   : rising-edge clock
//   wr_en   : write strobe
//   wr_addr : entry index to write
//   wr_data : {width, period} to store
//   rd_addr : entry index to read
//   rd_data : {width, period} at rd_addr
module pulse_seq_table #(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = 34
) (
  input  logic            clock,
  input  logic            wr_en,
  input  logic [AW-1:0]   wr_addr,
  input  logic [2*CW-1:0] wr_data,
  input  logic [AW-1:0]   rd_addr,
  output logic [2*CW-1:0] rd_data
);

  logic [2*CW-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse sequencer: plays table segments 0..LastSeg as (width, period) pairs
// on the Din/EN inputs of the PWM pulse counter. It can optionally loop.
// Each segment starts with one EN-low LOAD cycle. During that cycle the
// counter restarts and sees the new width. EN then stays high for `period`
// cycles.
//   Clock, Reset       : rising-edge clock, synchronous active-high reset
//   WrEn/WrAddr        : table write strobe and index
//   WrWidth/WrPeriod   : entry contents
//   LastSeg/Loop       : playback range and loop mode, latched at Start
//   Start/Stop         : playback control pulses. Stop has priority.
//   Width/EN           : to the counter Din/EN
//   SegIdx/Busy/Done   : status. Done pulses on normal completion.
module pulse_sequencer
  import pulse_sequencer_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3,
  parameter int CW    = CW_DEF
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          WrEn,
  input  logic [AW-1:0] WrAddr,
  input  logic [CW-1:0] WrWidth,
  input  logic [CW-1:0] WrPeriod,
  input  logic [AW-1:0] LastSeg,
  input  logic          Loop,
  input  logic          Start,
  input  logic          Stop,
  output logic [CW-1:0] Width,
  output logic          EN,
  output logic [AW-1:0] SegIdx,
  output logic          Busy,
  output logic          Done
);

  typedef struct packed {
    logic [CW-1:0] width;
    logic [CW-1:0] period;
  } entry_t;

  state_t        state, state_nxt;
  logic [CW-1:0] rem, rem_nxt;
  logic [CW-1:0] width_nxt;
  logic [AW-1:0] seg_nxt, last_q, last_nxt, load_addr;
  logic          loop_q, loop_nxt;
  logic          en_nxt, done_nxt, enter_load;
  entry_t        rd_entry;

  // The entry to be loaded next depends only on registered state. This keeps
  // the table read path free of any loop through the next-state logic.
  always_comb begin
    load_addr = '0;
    if (state == ST_RUN && SegIdx != last_q) load_addr = SegIdx + AW'(1);
  end

  pulse_seq_table #(.DEPTH(DEPTH), .AW(AW), .CW(CW)) u_table (
    .clock   (Clock),
    .wr_en   (WrEn),
    .wr_addr (WrAddr),
    .wr_data ({WrWidth, WrPeriod}),
    .rd_addr (load_addr),
    .rd_data (rd_entry)
  );

  always_comb begin
    state_nxt  = state;
    seg_nxt    = SegIdx;
    rem_nxt    = rem;
    width_nxt  = Width;
    last_nxt   = last_q;
    loop_nxt   = loop_q;
    en_nxt     = 1'b0;
    done_nxt   = 1'b0;
    enter_load = 1'b0;

    case (state)
      ST_IDLE: begin
        if (Start) begin
          state_nxt  = ST_LOAD;
          seg_nxt    = '0;
          last_nxt   = LastSeg;
          loop_nxt   = Loop;
          enter_load = 1'b1;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_RUN;
        en_nxt    = 1'b1;
      end
      ST_RUN: begin
        en_nxt = 1'b1;
        if (rem <= CW'(1)) begin
          en_nxt = 1'b0;
          if (SegIdx != last_q) begin
            state_nxt  = ST_LOAD;
            seg_nxt    = SegIdx + AW'(1);
            enter_load = 1'b1;
          end else if (loop_q) begin
            state_nxt  = ST_LOAD;
            seg_nxt    = '0;
            enter_load = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
            done_nxt  = 1'b1;
          end
        end else begin
          rem_nxt = rem - CW'(1);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase

    // The segment is latched on entry to LOAD. Table writes after this point
    // only affect the next play of that entry. A period of 0 plays as 1.
    if (enter_load) begin
      width_nxt = rd_entry.width;
      rem_nxt   = (rd_entry.period == '0) ? CW'(1) : rd_entry.period;
    end

    // Abort: drop to IDLE with no Done. Width, SegIdx and the counter hold.
    if (Stop) begin
      state_nxt = ST_IDLE;
      seg_nxt   = SegIdx;
      rem_nxt   = rem;
      width_nxt = Width;
      last_nxt  = last_q;
      loop_nxt  = loop_q;
      en_nxt    = 1'b0;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state  <= ST_IDLE;
      rem    <= '0;
      last_q <= '0;
      loop_q <= 1'b0;
      Width  <= '0;
      EN     <= 1'b0;
      SegIdx <= '0;
      Busy   <= 1'b0;
      Done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      rem    <= rem_nxt;
      last_q <= last_nxt;
      loop_q <= loop_nxt;
      Width  <= width_nxt;
      EN     <= en_nxt;
      SegIdx <= seg_nxt;
      Busy   <= (state_nxt != ST_IDLE);
      Done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_pulse_sequencer.sv
// Directed bench for pulse_sequencer. Expected per-cycle outputs are queued
// when stimulus is issued. Each cycle pops one entry and compares it #1 after
// the rising edge.
module tb_pulse_sequencer;
  import pulse_sequencer_pkg::*;

  localparam int AW = 3;
  localparam int CW = CW_DEF;

  logic          Clock = 1'b0;
  logic          Reset, WrEn, Loop, Start, Stop;
  logic [AW-1:0] WrAddr, LastSeg;
  logic [CW-1:0] WrWidth, WrPeriod;
  logic [CW-1:0] Width;
  logic          EN, Busy, Done;
  logic [AW-1:0] SegIdx;

  typedef struct packed {
    logic          en;
    logic [CW-1:0] width;
    logic [AW-1:0] seg;
    logic          busy;
    logic          done;
  } obs_t;

  obs_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc_n = 0;
  string phase = "init";

  pulse_sequencer #(.DEPTH(8), .AW(AW), .CW(CW)) dut (
    .Clock(Clock), .Reset(Reset), .WrEn(WrEn), .WrAddr(WrAddr),
    .WrWidth(WrWidth), .WrPeriod(WrPeriod), .LastSeg(LastSeg), .Loop(Loop),
    .Start(Start), .Stop(Stop), .Width(Width), .EN(EN), .SegIdx(SegIdx),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clock = ~Clock;

  task automatic push(input logic en, input logic [CW-1:0] w,
                      input logic [AW-1:0] s, input logic b, input logic d);
    obs_t o;
    o.en = en; o.width = w; o.seg = s; o.busy = b; o.done = d;
    exp_q.push_back(o);
  endtask

  // One LOAD cycle, then max(p,1) EN-high cycles.
  task automatic push_seg(input logic [CW-1:0] w, input logic [CW-1:0] p,
                          input logic [AW-1:0] s);
    int n;
    n = (p == 0) ? 1 : int'(p);
    push(1'b0, w, s, 1'b1, 1'b0);
    for (int i = 0; i < n; i++) push(1'b1, w, s, 1'b1, 1'b0);
  endtask

  task automatic cyc();
    obs_t got, exp;
    @(posedge Clock);
    #1;
    cyc_n++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      got = '{en: EN, width: Width, seg: SegIdx, busy: Busy, done: Done};
      tests++;
      assert (got === exp) else begin
        fails++;
        $error("FAIL %s cyc%0d: got en=%b w=%h seg=%0d busy=%b done=%b, exp en=%b w=%h seg=%0d busy=%b done=%b",
               phase, cyc_n, got.en, got.width, got.seg, got.busy, got.done,
               exp.en, exp.width, exp.seg, exp.busy, exp.done);
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [CW-1:0] w,
                    input logic [CW-1:0] p);
    WrEn = 1'b1; WrAddr = a; WrWidth = w; WrPeriod = p;
    cyc();
    WrEn = 1'b0;
  endtask

  localparam logic [CW-1:0] BIGW = 34'h2_0000_0005;

  initial begin
    Reset = 1'b1; WrEn = 1'b0; WrAddr = '0; WrWidth = '0; WrPeriod = '0;
    LastSeg = '0; Loop = 1'b0; Start = 1'b0; Stop = 1'b0;

    phase = "reset";
    repeat (2) push(1'b0, '0, '0, 1'b0, 1'b0);
    run(2);
    Reset = 1'b0;
    phase = "idle";
    repeat (3) push(1'b0, '0, '0, 1'b0, 1'b0);
    run(3);

    // Single segment (3,5): LOAD, 5 EN-high cycles, then Done.
    phase = "single";
    push(1'b0, '0, '0, 1'b0, 1'b0);
    wr(0, 3, 5);
    LastSeg = 0; Loop = 1'b0; Start = 1'b1;
    push_seg(3, 5, 0);
    push(1'b0, 3, 0, 1'b0, 1'b1);
    repeat (2) push(1'b0, 3, 0, 1'b0, 1'b0);
    cyc();
    Start = 1'b0;
    run(8);

    // Two segments, looping. A Start while busy must change nothing.
    phase = "loop";
    push(1'b0, 3, 0, 1'b0, 1'b0);
    wr(0, 1, 2);
    push(1'b0, 3, 0, 1'b0, 1'b0);
    wr(1, 4, 3);
    LastSeg = 1; Loop = 1'b1; Start = 1'b1;
    repeat (2) begin
      push_seg(1, 2, 0);
      push_seg(4, 3, 1);
    end
    push(1'b0, 1, 0, 1'b1, 1'b0);
    push(1'b1, 1, 0, 1'b1, 1'b0);
    cyc();
    Start = 1'b0;
    run(4);
    phase = "start_busy";
    Start = 1'b1; LastSeg = 0; Loop = 1'b0;
    cyc();
    Start = 1'b0;
    run(10);

    // Stop in RUN: idle next cycle, outputs hold, no Done.
    phase = "stop";
    Stop = 1'b1;
    repeat (3) push(1'b0, 1, 0, 1'b0, 1'b0);
    cyc();
    Stop = 1'b0;
    run(2);

    // Period 0 plays as 1. Upper width bits must pass through.
    phase = "period0";
    push(1'b0, 1, 0, 1'b0, 1'b0);
    wr(0, BIGW, 0);
    LastSeg = 0; Loop = 1'b0; Start = 1'b1;
    push_seg(BIGW, 0, 0);
    push(1'b0, BIGW, 0, 1'b0, 1'b1);
    push(1'b0, BIGW, 0, 1'b0, 1'b0);
    cyc();
    Start = 1'b0;
    run(3);

    // Start together with Stop while idle: stays idle.
    phase = "start_stop";
    Start = 1'b1; Stop = 1'b1;
    repeat (2) push(1'b0, BIGW, 0, 1'b0, 1'b0);
    cyc();
    Start = 1'b0; Stop = 1'b0;
    run(1);

    // Rewriting the running entry affects only its next play.
    phase = "write_run";
    push(1'b0, BIGW, 0, 1'b0, 1'b0);
    wr(0, 2, 3);
    LastSeg = 0; Loop = 1'b1; Start = 1'b1;
    push_seg(2, 3, 0);
    push_seg(7, 3, 0);
    push(1'b0, 7, 0, 1'b1, 1'b0);
    push(1'b1, 7, 0, 1'b1, 1'b0);
    cyc();
    Start = 1'b0;
    cyc();
    wr(0, 7, 3);
    run(7);

    // Reset in the middle of playback: back to reset values, no Done.
    phase = "reset_mid";
    Reset = 1'b1;
    push(1'b0, '0, '0, 1'b0, 1'b0);
    push(1'b0, '0, '0, 1'b0, 1'b0);
    cyc();
    Reset = 1'b0;
    cyc();

    phase = "drain";
    tests++;
    assert (exp_q.size() == 0) else begin
      fails++;
      $error("FAIL %s: %0d expectations left, exp 0", phase, exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
